// File: rtl/wb_port_arbiter_pkg.sv
// ============================================================================
// Module   : wb_port_arbiter_pkg
// Purpose  : Shared widths, types and helpers for the WB write-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_port_arbiter_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int REG_NUM     = 32;

    typedef logic [REG_ADDR_W-1:0]  reg_addr_t;
    typedef logic [INSTR_WIDTH-1:0] word_t;
    typedef logic [REG_NUM-1:0]     reg_mask_t;

    typedef struct packed {
        reg_addr_t addr;
        word_t     data;
    } lu_entry_t;

    function automatic reg_mask_t reg_onehot(input reg_addr_t a);
        return REG_NUM'(1) << a;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
// ============================================================================
// Module   : wb_port_arbiter_if
// Purpose  : WB stage / long-latency unit / register-file signals of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    logic      pipe_w_ena;
    reg_addr_t pipe_addr;
    word_t     pipe_data;
    logic      lu_valid;
    logic      lu_ready;
    reg_addr_t lu_addr;
    word_t     lu_data;
    logic      pipe_stall;
    logic      rf_w_ena;
    reg_addr_t rf_addr;
    word_t     rf_data;
    reg_mask_t pend_mask;

    modport slave (
        input  pipe_w_ena, pipe_addr, pipe_data, lu_valid, lu_addr, lu_data,
        output lu_ready, pipe_stall, rf_w_ena, rf_addr, rf_data, pend_mask
    );

    modport master (
        output pipe_w_ena, pipe_addr, pipe_data, lu_valid, lu_addr, lu_data,
        input  lu_ready, pipe_stall, rf_w_ena, rf_addr, rf_data, pend_mask
    );

endinterface

`default_nettype wire

// File: rtl/wb_port_arbiter_lu_fifo.sv
// ============================================================================
// Module   : wb_lu_fifo
// Purpose  : Small in-order FIFO of LU results with per-entry valid/addr taps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_lu_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_push,
    input  wire lu_entry_t              i_push_entry,
    input  wire logic                   i_pop,
    output lu_entry_t                   o_head,
    output logic                        o_full,
    output logic                        o_empty,
    output logic      [DEPTH-1:0]       o_ent_valid,
    output reg_addr_t [DEPTH-1:0]       o_ent_addr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    lu_entry_t         r_mem [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_ent_valid = r_valid;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_ent
            assign o_ent_addr[i] = r_mem[i].addr;
        end
    endgenerate

    // Storage carries no reset; r_valid alone decides what is live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
                r_valid[r_rd_ptr] <= 1'b0;
            end
            if (w_push) begin
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
                r_valid[r_wr_ptr] <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Shares the register-file write port between WB and queued LU results.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    wb_port_arbiter_if.slave  bus
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] C_MAX_WAIT = WAIT_W'(MAX_WAIT);

    lu_entry_t             w_head;
    lu_entry_t             w_push_entry;
    logic                  w_full;
    logic                  w_empty;
    logic [DEPTH-1:0]      w_ent_valid;
    reg_addr_t [DEPTH-1:0] w_ent_addr;

    logic                  w_push;
    logic                  w_slot_busy;
    logic                  w_force;
    logic                  w_drain;
    reg_mask_t             w_pend;
    logic [WAIT_W-1:0]     r_wait_cnt;

    // A handshake to $0 completes but never occupies a FIFO slot.
    assign w_push       = bus.lu_valid & ~w_full & (bus.lu_addr != '0);
    assign w_push_entry = '{addr: bus.lu_addr, data: bus.lu_data};
    assign bus.lu_ready = ~w_full;

    wb_lu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_drain),
        .o_head       (w_head),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_ent_valid  (w_ent_valid),
        .o_ent_addr   (w_ent_addr)
    );

    assign w_slot_busy = bus.pipe_w_ena & (bus.pipe_addr != '0);
    assign w_force     = ~w_empty & (r_wait_cnt == C_MAX_WAIT);
    assign w_drain     = ~w_empty & (~w_slot_busy | w_force);

    always_comb begin
        bus.rf_w_ena   = w_slot_busy;
        bus.rf_addr    = bus.pipe_addr;
        bus.rf_data    = bus.pipe_data;
        bus.pipe_stall = w_force & w_slot_busy;
        if (w_drain) begin
            bus.rf_w_ena = 1'b1;
            bus.rf_addr  = w_head.addr;
            bus.rf_data  = w_head.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (w_empty || w_drain) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != C_MAX_WAIT) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end
    end

    always_comb begin
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ent_valid[i]) begin
                w_pend = w_pend | reg_onehot(w_ent_addr[i]);
            end
        end
        w_pend[0] = 1'b0;
    end

    assign bus.pend_mask = w_pend;

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// ============================================================================
// Module   : tb_wb_port_arbiter
// Purpose  : Directed self-checking bench for wb_port_arbiter (DEPTH=2, MAX_WAIT=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_port_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(
        .DEPTH    (2),
        .MAX_WAIT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pipe(input logic ena, input logic [4:0] a, input logic [31:0] d);
        bus.pipe_w_ena = ena;
        bus.pipe_addr  = a;
        bus.pipe_data  = d;
    endtask

    task automatic drive_lu(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.lu_valid = v;
        bus.lu_addr  = a;
        bus.lu_data  = d;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // ---- 1: reset holds FIFO empty even with lu_valid asserted
        rst = 1'b1;
        drive_pipe(1'b1, 5'd2, 32'h0000_00AA);
        drive_lu(1'b1, 5'd3, 32'h0000_0333);
        tick();
        tick();
        chk("rst_lu_ready", 32'(bus.lu_ready), 32'd1);
        chk("rst_pend", bus.pend_mask, 32'h0);
        chk("rst_stall", 32'(bus.pipe_stall), 32'd0);
        chk("rst_rf_ena", 32'(bus.rf_w_ena), 32'd1);
        chk("rst_rf_addr", 32'(bus.rf_addr), 32'd2);
        chk("rst_rf_data", bus.rf_data, 32'h0000_00AA);
        drive_pipe(1'b1, 5'd0, 32'h0000_00BB);
        #1;
        chk("rst_r0_ena", 32'(bus.rf_w_ena), 32'd0);
        drive_lu(1'b0, 5'd0, 32'h0);
        drive_pipe(1'b0, 5'd0, 32'h0);
        #1;
        rst = 1'b0;
        tick();
        chk("post_rst_ena", 32'(bus.rf_w_ena), 32'd0);

        // ---- 2: idle drain, one cycle after handshake
        drive_lu(1'b1, 5'd5, 32'h0000_1234);
        #1;
        chk("idle_no_bypass", 32'(bus.rf_w_ena), 32'd0);
        tick();
        drive_lu(1'b0, 5'd0, 32'h0);
        #1;
        chk("idle_ena", 32'(bus.rf_w_ena), 32'd1);
        chk("idle_addr", 32'(bus.rf_addr), 32'd5);
        chk("idle_data", bus.rf_data, 32'h0000_1234);
        chk("idle_pend", bus.pend_mask, 32'h0000_0020);
        tick();
        chk("idle_pend_clr", bus.pend_mask, 32'h0);
        chk("idle_ena_clr", 32'(bus.rf_w_ena), 32'd0);

        // ---- 3: full FIFO with busy pipe; third offer is held off
        drive_pipe(1'b1, 5'd10, 32'h0000_0A00);
        drive_lu(1'b1, 5'd3, 32'h0000_0033);
        tick();
        drive_lu(1'b1, 5'd4, 32'h0000_0044);
        #1;
        chk("full_rdy_before", 32'(bus.lu_ready), 32'd1);
        chk("full_pipe_pass", 32'(bus.rf_addr), 32'd10);
        tick();
        drive_lu(1'b1, 5'd6, 32'h0000_0066);
        #1;
        chk("full_rdy", 32'(bus.lu_ready), 32'd0);
        chk("full_pend", bus.pend_mask, 32'h0000_0018);
        tick();
        tick();
        chk("full_rdy_hold", 32'(bus.lu_ready), 32'd0);
        chk("full_no_stall", 32'(bus.pipe_stall), 32'd0);
        tick();
        chk("full_force_stall", 32'(bus.pipe_stall), 32'd1);
        chk("full_force_addr", 32'(bus.rf_addr), 32'd3);
        chk("full_force_data", bus.rf_data, 32'h0000_0033);
        tick();
        drive_pipe(1'b0, 5'd0, 32'h0);
        drive_lu(1'b0, 5'd0, 32'h0);
        #1;
        chk("full_rdy_back", 32'(bus.lu_ready), 32'd1);
        chk("full_pend_r4", bus.pend_mask, 32'h0000_0010);
        chk("full_drain_addr", 32'(bus.rf_addr), 32'd4);
        chk("full_drain_data", bus.rf_data, 32'h0000_0044);
        tick();
        chk("full_pend_empty", bus.pend_mask, 32'h0);
        chk("full_final_ena", 32'(bus.rf_w_ena), 32'd0);

        // ---- 4: starvation; r6 is stalled once and commits the cycle after
        begin
            int commits;
            commits = 0;
            for (int k = 0; k < 10; k++) begin
                logic [4:0] pa;
                pa = (k <= 5) ? 5'(k + 1) : 5'(k);
                drive_pipe(1'b1, pa, 32'h100 + 32'(pa));
                if (k == 0) drive_lu(1'b1, 5'd7, 32'h0000_0077);
                else        drive_lu(1'b0, 5'd0, 32'h0);
                #1;
                chk($sformatf("starve_stall_%0d", k), 32'(bus.pipe_stall), (k == 5) ? 32'd1 : 32'd0);
                chk($sformatf("starve_addr_%0d", k), 32'(bus.rf_addr), (k == 5) ? 32'd7 : 32'(pa));
                chk($sformatf("starve_data_%0d", k), bus.rf_data,
                    (k == 5) ? 32'h0000_0077 : 32'h100 + 32'(pa));
                if (!bus.pipe_stall) commits++;
                tick();
            end
            chk("starve_commits", 32'(commits), 32'd9);
            drive_pipe(1'b0, 5'd0, 32'h0);
            #1;
            chk("starve_pend_clr", bus.pend_mask, 32'h0);
        end

        // ---- 5: $0 handling on both sides
        drive_lu(1'b1, 5'd0, 32'h0000_DEAD);
        #1;
        chk("r0_lu_ready", 32'(bus.lu_ready), 32'd1);
        tick();
        drive_lu(1'b0, 5'd0, 32'h0);
        #1;
        chk("r0_lu_dropped", 32'(bus.rf_w_ena), 32'd0);
        chk("r0_lu_pend", bus.pend_mask, 32'h0);
        drive_lu(1'b1, 5'd9, 32'h0000_0099);
        tick();
        drive_lu(1'b0, 5'd0, 32'h0);
        drive_pipe(1'b1, 5'd0, 32'h0000_00FF);
        #1;
        chk("r0_pipe_drain_ena", 32'(bus.rf_w_ena), 32'd1);
        chk("r0_pipe_drain_addr", 32'(bus.rf_addr), 32'd9);
        chk("r0_pipe_drain_data", bus.rf_data, 32'h0000_0099);
        chk("r0_pipe_no_stall", 32'(bus.pipe_stall), 32'd0);
        tick();
        chk("r0_pipe_after", 32'(bus.rf_w_ena), 32'd0);

        // ---- 6: asynchronous reset with two queued entries
        drive_pipe(1'b1, 5'd12, 32'h0000_0C00);
        drive_lu(1'b1, 5'd20, 32'h0000_0020);
        tick();
        drive_lu(1'b1, 5'd21, 32'h0000_0021);
        tick();
        drive_lu(1'b0, 5'd0, 32'h0);
        drive_pipe(1'b0, 5'd0, 32'h0);
        #1;
        chk("arst_pend_before", bus.pend_mask, 32'h0030_0000);
        chk("arst_rdy_before", 32'(bus.lu_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("arst_pend", bus.pend_mask, 32'h0);
        chk("arst_rdy", 32'(bus.lu_ready), 32'd1);
        chk("arst_rf_ena", 32'(bus.rf_w_ena), 32'd0);
        #1;
        rst = 1'b0;
        tick();
        chk("arst_no_stale", 32'(bus.rf_w_ena), 32'd0);
        chk("arst_pend_after", bus.pend_mask, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
